nios_v1_hex_display: RTL and testbench

Parametrised Avalon-MM slave driving `NUM_DIGITS` seven-segment digits from one register bank on the Nios system interconnect. Each digit runs in raw-segment or hex-decode mode. Digits can be blanked globally or blinked individually from a programmable blink timer. It replaces the per-digit single-register PIOs, so software drives a whole display through one slave.

---
 rtl/nios_v1_hex_display.sv | 160 ++++++++++++++++
 tb/tb_nios_v1_hex_display.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_v1_hex_display.sv
// nios_v1_hex_display
// Avalon-MM slave that drives NUM_DIGITS seven-segment digits from one
// register bank. Each digit can show raw segments or a decoded hex nibble.
// All digits can be blanked together, and selected digits can blink from a
// programmable half-period timer. Segment outputs are active-low and
// registered, so they have one cycle of latency.
module nios_v1_hex_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_WIDTH   = 7,
    parameter int BLINK_DIV_W = 24
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [3:0]                      address,
    input  logic                            chipselect,
    input  logic                            write_n,
    input  logic [31:0]                     writedata,
    output logic [31:0]                     readdata,
    output logic [NUM_DIGITS*SEG_WIDTH-1:0] out_port
);

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_PERIOD = 4'd9;
    localparam logic [3:0] ADDR_STATUS = 4'd10;

    logic [SEG_WIDTH-1:0]            digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]           decode_en;
    logic [NUM_DIGITS-1:0]           blink_mask;
    logic                            blank;
    logic [BLINK_DIV_W-1:0]          period;
    logic [BLINK_DIV_W-1:0]          cnt;
    logic                            phase;
    logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_next;
    logic                            wr_en;
    logic                            unused_wdata;

    assign wr_en = chipselect && !write_n;

    // Fold in the writedata bits that no register stores.
    assign unused_wdata = ^writedata;

    // Active-low hex font: bit0=a ... bit6=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        case (value)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Digit and control registers, written from the slave port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the digit array is reset element by element because software
            // expects every digit to read 0 after reset, so it cannot be left as
            // an unreset RAM.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
            decode_en  <= '0;
            blink_mask <= '0;
            blank      <= 1'b0;
        end else if (wr_en) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the values from before this edge.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) begin
                    digit_reg[i] <= writedata[SEG_WIDTH-1:0];
                end
            end
            if (address == ADDR_CTRL) begin
                decode_en  <= writedata[NUM_DIGITS-1:0];
                blink_mask <= writedata[8 +: NUM_DIGITS];
                blank      <= writedata[31];
            end
        end
    end

    // Blink timer. A PERIOD write restarts the count and takes priority over a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (wr_en && address == ADDR_PERIOD) begin
            period <= writedata[BLINK_DIV_W-1:0];
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (period == '0) begin
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (cnt == period - 1'b1) begin
            cnt    <= '0;
            phase  <= ~phase;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    // Per-digit segment selection: decode or raw, then blank or blink.
    always_comb begin : seg_select
        logic [SEG_WIDTH-1:0] seg;
        // NOTE: outputs get a default before any branch so no latch is inferred.
        seg_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = digit_reg[i];
            if (decode_en[i]) begin
                // The decimal point (bit 7, when present) passes through.
                seg[6:0] = hex_to_seg(digit_reg[i][3:0]);
            end
            if (blank || (blink_mask[i] && phase)) begin
                seg = '1;
            end
            seg_next[i*SEG_WIDTH +: SEG_WIDTH] = seg;
        end
    end

    // Output register for the segment pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= seg_next;
        end
    end

    // Zero-wait-state read mux; unmapped addresses and bits read as 0.
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(i)) begin
                readdata[SEG_WIDTH-1:0] = digit_reg[i];
            end
        end
        case (address)
            ADDR_CTRL: begin
                readdata[NUM_DIGITS-1:0]  = decode_en;
                readdata[8 +: NUM_DIGITS] = blink_mask;
                readdata[31]              = blank;
            end
            ADDR_PERIOD: readdata[BLINK_DIV_W-1:0] = period;
            ADDR_STATUS: readdata[0]               = phase;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_nios_v1_hex_display.sv
// Directed testbench for nios_v1_hex_display with default parameters
// (4 digits, 7 segments, 24-bit blink divider).
module tb_nios_v1_hex_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [27:0] out_port;

    int checks = 0;
    int errors = 0;

    // Expected displays: digit0 = dec 5, digit1 = raw 0, digit2 = raw 0x55, digit3 = dec F.
    localparam logic [27:0] DISP_BASE  = 28'h1D54012;
    localparam logic [27:0] DISP_BLINK = 28'h1D57F92;

    nios_v1_hex_display dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Single write: driven on the falling edge, sampled on the next rising edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Read: readdata is combinational, sampled shortly after the address is set.
    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, d, 32'h0);
            end
        end
        checks++;
        if (out_port !== 28'h0) begin
            errors++;
            $display("FAIL reset_out_port got=%h exp=%h", out_port, 28'h0);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        do_write(4'd0, 32'h5);
        do_write(4'd8, 32'h1);
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== 28'h0000012) begin
            errors++;
            $display("FAIL decode_digit0 got=%h exp=%h", out_port, 28'h0000012);
        end
        do_read(4'd0, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL read_digit0 got=%h exp=%h", d, 32'h5);
        end
        do_write(4'd3, 32'h0F);
        do_write(4'd2, 32'h55);
        do_write(4'd8, 32'h9);
        // One cycle of latency: digit3 still raw 0x0F at the update edge.
        checks++;
        if (out_port !== 28'h1F54012) begin
            errors++;
            $display("FAIL output_latency got=%h exp=%h", out_port, 28'h1F54012);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== DISP_BASE) begin
            errors++;
            $display("FAIL decode_mixed got=%h exp=%h", out_port, DISP_BASE);
        end
    endtask

    task automatic test_blank();
        logic [31:0] d;
        do_write(4'd8, 32'h8000_0009);
        checks++;
        if (out_port !== DISP_BASE) begin
            errors++;
            $display("FAIL blank_latency got=%h exp=%h", out_port, DISP_BASE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL blank_on got=%h exp=%h", out_port, 28'hFFFFFFF);
        end
        do_read(4'd8, d);
        checks++;
        if (d !== 32'h8000_0009) begin
            errors++;
            $display("FAIL read_ctrl_blank got=%h exp=%h", d, 32'h8000_0009);
        end
        do_write(4'd8, 32'h9);
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== DISP_BASE) begin
            errors++;
            $display("FAIL blank_off got=%h exp=%h", out_port, DISP_BASE);
        end
    endtask

    task automatic test_blink();
        logic        exp_phase;
        logic [27:0] exp_out;
        do_write(4'd8, 32'h0209);
        do_write(4'd9, 32'd3);
        address    = 4'd10;
        chipselect = 1'b1;
        write_n    = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            exp_phase = ((n / 3) % 2) == 1;
            exp_out   = (((n - 1) / 3) % 2 == 1) ? DISP_BLINK : DISP_BASE;
            checks++;
            if (readdata[0] !== exp_phase) begin
                errors++;
                $display("FAIL blink_phase n=%0d got=%b exp=%b", n, readdata[0], exp_phase);
            end
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL blink_out n=%0d got=%h exp=%h", n, out_port, exp_out);
            end
        end
        chipselect = 1'b0;
    endtask

    task automatic test_period_rewrite();
        logic        exp_phase;
        logic [31:0] d;
        do_write(4'd9, 32'd3);
        repeat (2) @(posedge clk);
        // cnt is now P-1; the rewrite lands on the edge that would wrap.
        do_write(4'd9, 32'd3);
        address = 4'd10;
        #1;
        checks++;
        if (readdata[0] !== 1'b0) begin
            errors++;
            $display("FAIL rewrite_no_toggle got=%b exp=%b", readdata[0], 1'b0);
        end
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            exp_phase = (n == 3);
            checks++;
            if (readdata[0] !== exp_phase) begin
                errors++;
                $display("FAIL rewrite_restart n=%0d got=%b exp=%b", n, readdata[0], exp_phase);
            end
        end
        do_read(4'd9, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL read_period got=%h exp=%h", d, 32'd3);
        end
        do_write(4'd9, 32'd0);
        address = 4'd10;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (readdata[0] !== 1'b0) begin
                errors++;
                $display("FAIL period_zero n=%0d got=%b exp=%b", n, readdata[0], 1'b0);
            end
        end
        checks++;
        if (out_port !== DISP_BASE) begin
            errors++;
            $display("FAIL period_zero_out got=%h exp=%h", out_port, DISP_BASE);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [31:0] exp_rd [16];
        do_write(4'd12, 32'hFFFF_FFFF);
        do_write(4'd10, 32'hFFFF_FFFF);
        do_write(4'd5,  32'hFFFF_FFFF);
        do_write(4'd15, 32'hFFFF_FFFF);
        for (int a = 0; a < 16; a++) exp_rd[a] = 32'h0;
        exp_rd[0] = 32'h5;
        exp_rd[2] = 32'h55;
        exp_rd[3] = 32'h0F;
        exp_rd[8] = 32'h0209;
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), d);
            checks++;
            if (d !== exp_rd[a]) begin
                errors++;
                $display("FAIL unmapped_read addr=%0d got=%h exp=%h", a, d, exp_rd[a]);
            end
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        address    = 4'd0;
        writedata  = 32'h7;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h5) begin
            errors++;
            $display("FAIL read_old_value got=%h exp=%h", readdata, 32'h5);
        end
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        checks++;
        if (readdata !== 32'h7) begin
            errors++;
            $display("FAIL read_new_value got=%h exp=%h", readdata, 32'h7);
        end
    endtask

    task automatic test_reset_mid_blink();
        do_write(4'd8, 32'h8000_0F0F);
        do_write(4'd9, 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b0;
        address    = 4'd0;
        writedata  = 32'h3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        checks++;
        if (out_port !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid_out got=%h exp=%h", out_port, 28'h0);
        end
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #0.2;
            checks++;
            if (readdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_read addr=%0d got=%h exp=%h", a, readdata, 32'h0);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_port !== 28'h0) begin
            errors++;
            $display("FAIL post_reset_out got=%h exp=%h", out_port, 28'h0);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_blank();
        test_blink();
        test_period_rewrite();
        test_unmapped();
        test_read_during_write();
        test_reset_mid_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
